// File: rtl/sine_seq_pkg.sv
// Shared types, constants and the quadrant helpers for the quarter-wave sine sequencer.
package sine_seq_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  localparam int SEQ_ADDR_W = 7;
  localparam int SEQ_DATA_W = 9;
  localparam int SEQ_OUT_W  = 10;
  localparam logic [SEQ_OUT_W-1:0] MID = 10'd512;

  // Odd quadrants walk the quarter table backwards.
  function automatic logic [SEQ_ADDR_W-1:0] mirror_addr(input logic q0,
                                                        input logic [SEQ_ADDR_W-1:0] idx);
    return q0 ? ~idx : idx;
  endfunction

  // Second half-wave sits below mid-scale.
  function automatic logic [SEQ_OUT_W-1:0] fold_sample(input logic q1,
                                                       input logic [SEQ_DATA_W-1:0] data);
    logic [SEQ_OUT_W-1:0] ext;
    ext = {{(SEQ_OUT_W-SEQ_DATA_W){1'b0}}, data};
    return q1 ? (MID - ext) : (MID + ext);
  endfunction

endpackage

// File: rtl/sine_sequencer_tick_divider.sv
// Sample-rate prescaler: counts 0..div while running and flags the terminal count.
module tick_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;

  assign tick = run && (cnt_q == div);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/sine_sequencer.sv
// Quarter-wave sine sequencer: phase accumulator, ROM address mirroring, full-wave
// sample rebuild and a shadowed config port applied on sample boundaries.
//   state | meaning
//   IDLE  | phase and prescaler cleared, sample parked at mid-scale
//   RUN   | prescaler ticking, one ROM request per tick
module sine_sequencer
  import sine_seq_pkg::*;
#(
  parameter int               PHASE_W  = 16,
  parameter int               ADDR_W   = SEQ_ADDR_W,
  parameter int               DATA_W   = SEQ_DATA_W,
  parameter int               OUT_W    = SEQ_OUT_W,
  parameter int               DIV_W    = 16,
  parameter logic [PHASE_W-1:0] DEF_STEP = 16'h0100,
  parameter logic [DIV_W-1:0]   DEF_DIV  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_step,
  input  logic [DIV_W-1:0]   cfg_div,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic [OUT_W-1:0]   sample,
  output logic               sample_valid
);

  state_t               state_q;
  logic [PHASE_W-1:0]   phase_q, step_q, sh_step_q;
  logic [DIV_W-1:0]     div_q, sh_div_q;
  logic                 pending_q;
  logic [ADDR_W-1:0]    rom_addr_q;
  logic                 vld_p1_q, vld_p2_q, q1_p1_q, q1_p2_q;
  logic [OUT_W-1:0]     sample_q;
  logic                 sample_valid_q;
  logic                 run, tick;

  assign run          = (state_q == RUN) && enable;
  assign cfg_ready    = !pending_q;
  assign rom_addr     = rom_addr_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;

  tick_divider #(.DIV_W(DIV_W)) u_div (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .clear (!run),
    .div   (div_q),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      phase_q        <= '0;
      step_q         <= DEF_STEP;
      div_q          <= DEF_DIV;
      sh_step_q      <= DEF_STEP;
      sh_div_q       <= DEF_DIV;
      pending_q      <= 1'b0;
      rom_addr_q     <= '0;
      vld_p1_q       <= 1'b0;
      vld_p2_q       <= 1'b0;
      q1_p1_q        <= 1'b0;
      q1_p2_q        <= 1'b0;
      sample_q       <= MID;
      sample_valid_q <= 1'b0;
    end else begin
      if (cfg_valid && !pending_q) begin
        sh_step_q <= cfg_step;
        sh_div_q  <= cfg_div;
        pending_q <= 1'b1;
      end
      // The applying tick still advances with the old step and compares against the old div.
      if (pending_q && ((state_q == IDLE) || tick)) begin
        step_q    <= sh_step_q;
        div_q     <= sh_div_q;
        pending_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          phase_q        <= '0;
          vld_p1_q       <= 1'b0;
          vld_p2_q       <= 1'b0;
          sample_valid_q <= 1'b0;
          sample_q       <= MID;
          if (enable) state_q <= RUN;
        end
        RUN: begin
          if (!enable) begin
            state_q        <= IDLE;
            phase_q        <= '0;
            vld_p1_q       <= 1'b0;
            vld_p2_q       <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_q       <= MID;
          end else begin
            if (tick) begin
              rom_addr_q <= mirror_addr(phase_q[PHASE_W-2], phase_q[PHASE_W-3 -: ADDR_W]);
              phase_q    <= phase_q + step_q;
              q1_p1_q    <= phase_q[PHASE_W-1];
            end
            vld_p1_q       <= tick;
            vld_p2_q       <= vld_p1_q;
            q1_p2_q        <= q1_p1_q;
            sample_valid_q <= vld_p2_q;
            if (vld_p2_q) sample_q <= fold_sample(q1_p2_q, rom_data);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sine_sequencer.sv
// Directed bench for sine_sequencer with a synchronous quarter-wave ROM model.
module tb_sine_sequencer;

  logic        clk = 1'b0;
  logic        rst, enable, cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_step;
  logic [15:0] cfg_div;
  logic [6:0]  rom_addr;
  logic [8:0]  rom_data = '0;
  logic [9:0]  sample;
  logic        sample_valid;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  sine_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_step     (cfg_step),
    .cfg_div      (cfg_div),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sample       (sample),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  // rom[0]=0, rom[127]=511, strictly increasing in between.
  function automatic int rom_f(input int a);
    return a * 4 + a / 32;
  endfunction

  always @(posedge clk) rom_data <= 9'(rom_f(int'(rom_addr)));

  function automatic int exp_addr(input int k, input int stp);
    logic [15:0] ph;
    int idx;
    ph  = 16'(k * stp);
    idx = int'(ph[13:7]);
    return ph[14] ? 127 - idx : idx;
  endfunction

  function automatic int exp_samp(input int k, input int stp);
    logic [15:0] ph;
    ph = 16'(k * stp);
    return ph[15] ? 512 - rom_f(exp_addr(k, stp)) : 512 + rom_f(exp_addr(k, stp));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int a4[4];
    int s4[4];
    a4 = '{0, 127, 0, 127};
    s4 = '{512, 1023, 512, 1};

    rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_step = '0; cfg_div = '0;
    repeat (3) step_cycle();
    rst = 1'b0;

    // Idle after reset
    repeat (20) begin
      step_cycle();
      check("idle_valid", 32'(sample_valid), 0);
    end
    check("idle_sample", 32'(sample), 512);
    check("idle_ready", 32'(cfg_ready), 1);
    check("idle_addr", 32'(rom_addr), 0);

    // Config in IDLE applies the next cycle
    cfg_valid = 1'b1; cfg_step = 16'h4000; cfg_div = 16'd0;
    step_cycle();
    cfg_valid = 1'b0;
    check("idle_cfg_ready_low", 32'(cfg_ready), 0);
    step_cycle();
    check("idle_cfg_ready_high", 32'(cfg_ready), 1);

    // Quadrant sweep, one sample per cycle
    enable = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step_cycle();
      if (n >= 2) check("q_addr", 32'(rom_addr), 32'(a4[(n - 2) % 4]));
      if (n >= 4) begin
        check("q_valid", 32'(sample_valid), 1);
        check("q_sample", 32'(sample), 32'(s4[(n - 4) % 4]));
      end else begin
        check("q_valid_lat", 32'(sample_valid), 0);
      end
    end

    enable = 1'b0;
    step_cycle();
    check("stop_mid", 32'(sample), 512);
    cfg_valid = 1'b1; cfg_step = 16'h0400; cfg_div = 16'd3;
    step_cycle();
    cfg_valid = 1'b0;
    step_cycle();

    // step 0x0400, div 3: tick k at 4+4k, address at 5+4k, sample at 7+4k
    enable = 1'b1;
    cyc = 0;
    while (cyc < 287) begin
      step_cycle();
      if (cyc >= 7 && (cyc - 7) % 4 == 0) begin
        check("d3_valid", 32'(sample_valid), 1);
        check("d3_sample", 32'(sample), 32'(exp_samp((cyc - 7) / 4, 16'h0400)));
      end else begin
        check("d3_novalid", 32'(sample_valid), 0);
      end
      if (cyc >= 5 && (cyc - 5) % 4 == 0)
        check("d3_addr", 32'(rom_addr), 32'(exp_addr((cyc - 5) / 4, 16'h0400)));
      if (cyc == 5 + 4 * 64) check("d3_wrap_addr", 32'(rom_addr), 0);
    end

    // Offer div=9 on the tick at 288: old period kept through 292, then 10 cycles
    step_cycle();
    cfg_valid = 1'b1; cfg_step = 16'h0400; cfg_div = 16'd9;
    while (cyc < 312) begin
      step_cycle();
      cfg_valid = 1'b0;
      check("d9_ready", 32'(cfg_ready), (cyc >= 293) ? 1 : 0);
      check("d9_valid", 32'(sample_valid),
            (cyc == 291 || cyc == 295 || cyc == 305) ? 1 : 0);
    end

    // Stop one cycle after the tick at 312: its sample never appears
    step_cycle();
    enable = 1'b0;
    step_cycle();
    check("drop_mid", 32'(sample), 512);
    check("drop_valid", 32'(sample_valid), 0);
    while (cyc < 320) begin
      step_cycle();
      check("drop_novalid", 32'(sample_valid), 0);
    end
    enable = 1'b1;
    while (cyc < 333) begin
      step_cycle();
      if (cyc == 331) check("restart_addr", 32'(rom_addr), 0);
      check("restart_valid", 32'(sample_valid), (cyc == 333) ? 1 : 0);
      if (cyc == 333) check("restart_sample", 32'(sample), 512);
    end

    // Reset while a config is pending
    step_cycle();
    step_cycle();
    cfg_valid = 1'b1; cfg_step = 16'h2000; cfg_div = 16'd5;
    step_cycle();
    cfg_valid = 1'b0;
    check("pend_ready", 32'(cfg_ready), 0);
    rst = 1'b1;
    step_cycle();
    rst = 1'b0;
    check("rst_ready", 32'(cfg_ready), 1);
    check("rst_sample", 32'(sample), 512);
    check("rst_valid", 32'(sample_valid), 0);
    check("rst_addr", 32'(rom_addr), 0);
    while (cyc < 350) begin
      step_cycle();
      if (cyc >= 339) check("def_addr", 32'(rom_addr), 32'(2 * (cyc - 339)));
      if (cyc >= 341) begin
        check("def_valid", 32'(sample_valid), 1);
        check("def_sample", 32'(sample), 32'(512 + rom_f(2 * (cyc - 341))));
      end else begin
        check("def_novalid", 32'(sample_valid), 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
